// File: rtl/renode_inputs_filter.sv
`default_nettype none
// ============================================================================
// Module      : renode_inputs_filter
// Description : Conditions raw, possibly asynchronous DUT interrupt/GPIO lines
//               before the Renode input-forwarding block. Each line is
//               synchronized, glitch-filtered and then held for a minimum
//               time, so that every accepted edge is sampled exactly once
//               downstream. Per-line change strobes and a saturating glitch
//               counter are provided for debug.
// Revision    : 1.0 - initial release
// ============================================================================
module renode_inputs_filter #(
  parameter int                    INPUTS_COUNT    = 1,
  parameter int                    SYNC_STAGES     = 2,
  parameter int                    FILTER_CYCLES   = 4,
  parameter int                    MIN_HOLD_CYCLES = 2,
  parameter logic [INPUTS_COUNT-1:0] RESET_VALUE   = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [INPUTS_COUNT-1:0] raw_i,
  input  logic                    freeze,
  input  logic                    glitch_clear,
  output logic [INPUTS_COUNT-1:0] filtered_o,
  output logic [INPUTS_COUNT-1:0] change_o,
  output logic [15:0]             glitch_count
);

  // Qualification and hold lengths in the width of the per-line counter.
  localparam logic [7:0] c_filter_cycles = 8'(FILTER_CYCLES);
  localparam logic [7:0] c_min_hold      = 8'(MIN_HOLD_CYCLES);

  // Per-line filter states.
  //   ST_STABLE  : synchronized value agrees with the filtered output
  //   ST_QUALIFY : a difference is being counted toward acceptance
  //   ST_HOLD    : output frozen after an accepted change
  typedef enum logic [1:0] {
    ST_STABLE  = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Synchronizer chain: stage 0 samples the raw pins, the last stage is the
  // first value safe to use in the clk domain.
  // --------------------------------------------------------------------------
  logic [INPUTS_COUNT-1:0] r_sync [SYNC_STAGES];
  logic [INPUTS_COUNT-1:0] w_sync;

  // First synchronizer stage captures the asynchronous pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync[0] <= RESET_VALUE;
    end else begin
      r_sync[0] <= raw_i;
    end
  end

  genvar s;
  generate
    for (s = 1; s < SYNC_STAGES; s++) begin : g_sync_stage
      // Remaining synchronizer stages shift the sampled value along.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync[s] <= RESET_VALUE;
        end else begin
          r_sync[s] <= r_sync[s-1];
        end
      end
    end
  endgenerate

  assign w_sync = r_sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Per-line qualification / hold state machines. Lines are fully
  // independent; the only shared piece is the glitch increment below.
  // --------------------------------------------------------------------------
  logic [INPUTS_COUNT-1:0] w_glitch;

  genvar i;
  generate
    for (i = 0; i < INPUTS_COUNT; i++) begin : g_line
      state_t     r_state;
      logic [7:0] r_cnt;
      logic       r_filt;
      logic       r_change;

      // Filter FSM: qualify a difference for FILTER_CYCLES cycles, then
      // update the output, strobe once, and hold for MIN_HOLD_CYCLES.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state  <= ST_STABLE;
          r_cnt    <= 8'd0;
          r_filt   <= RESET_VALUE[i];
          r_change <= 1'b0;
        end else if (freeze) begin
          // While the simulation side is in reset the line tracks the
          // synchronized input directly; no strobes are produced, so the
          // resume point is simply whatever filtered value is current.
          r_state  <= ST_STABLE;
          r_cnt    <= 8'd0;
          r_filt   <= w_sync[i];
          r_change <= 1'b0;
        end else begin
          r_change <= 1'b0;
          case (r_state)
            ST_STABLE: begin
              if (w_sync[i] != r_filt) begin
                if (FILTER_CYCLES == 1) begin
                  // A single differing cycle is already enough.
                  r_filt   <= w_sync[i];
                  r_change <= 1'b1;
                  r_state  <= ST_HOLD;
                  r_cnt    <= 8'd1;
                end else begin
                  r_state <= ST_QUALIFY;
                  r_cnt   <= 8'd1;
                end
              end
            end
            ST_QUALIFY: begin
              if (w_sync[i] == r_filt) begin
                // Input fell back before qualifying: count as a glitch.
                r_state <= ST_STABLE;
                r_cnt   <= 8'd0;
              end else if (r_cnt + 8'd1 == c_filter_cycles) begin
                r_filt   <= w_sync[i];
                r_change <= 1'b1;
                r_state  <= ST_HOLD;
                r_cnt    <= 8'd1;
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end
            ST_HOLD: begin
              // The input is ignored here; any difference still present on
              // exit gets evaluated from the following cycle onwards.
              if (r_cnt == c_min_hold) begin
                r_state <= ST_STABLE;
                r_cnt   <= 8'd0;
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end
            default: begin
              r_state <= ST_STABLE;
              r_cnt   <= 8'd0;
            end
          endcase
        end
      end

      // A glitch is a qualifying line whose input returned to the filtered
      // value; freeze suppresses all filtering, hence all glitches.
      assign w_glitch[i]   = (r_state == ST_QUALIFY) && (w_sync[i] == r_filt) && !freeze;
      assign filtered_o[i] = r_filt;
      assign change_o[i]   = r_change;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Saturating glitch counter.
  // --------------------------------------------------------------------------
  logic [6:0]  w_glitch_inc;
  logic [16:0] w_glitch_sum;
  logic [15:0] r_glitch_count;

  // Number of lines glitching in the current cycle.
  always_comb begin
    w_glitch_inc = '0;
    for (int k = 0; k < INPUTS_COUNT; k++) begin
      w_glitch_inc = w_glitch_inc + 7'(w_glitch[k]);
    end
  end

  assign w_glitch_sum = {1'b0, r_glitch_count} + {10'd0, w_glitch_inc};

  // Accumulate glitches, clamping at all-ones; clear wins over any increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_glitch_count <= 16'd0;
    end else if (glitch_clear) begin
      r_glitch_count <= 16'd0;
    end else if (!freeze) begin
      r_glitch_count <= w_glitch_sum[16] ? 16'hFFFF : w_glitch_sum[15:0];
    end
  end

  assign glitch_count = r_glitch_count;

endmodule
`default_nettype wire

// File: tb/tb_renode_inputs_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_renode_inputs_filter
// Description : Self-checking bench for renode_inputs_filter (4 lines,
//               default sync/filter/hold). Expected change strobes are queued
//               when stimulus is applied and matched as the DUT strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_renode_inputs_filter;

  localparam int N    = 4;
  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int HOLD = 2;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] raw_i;
  logic         freeze;
  logic         glitch_clear;
  logic [N-1:0] filtered_o;
  logic [N-1:0] change_o;
  logic [15:0]  glitch_count;

  renode_inputs_filter #(
    .INPUTS_COUNT    (N),
    .SYNC_STAGES     (SYNC),
    .FILTER_CYCLES   (FILT),
    .MIN_HOLD_CYCLES (HOLD),
    .RESET_VALUE     ('0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .raw_i        (raw_i),
    .freeze       (freeze),
    .glitch_clear (glitch_clear),
    .filtered_o   (filtered_o),
    .change_o     (change_o),
    .glitch_count (glitch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after "@(posedge clk); #1" it holds the index of that edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected strobe: edge index, change_o mask, filtered_o value at that edge.
  typedef struct {
    int           at;
    logic [N-1:0] mask;
    logic [N-1:0] filt;
  } ev_t;
  ev_t sb[$];

  task automatic expect_event(input int at, input logic [N-1:0] mask, input logic [N-1:0] filt);
    ev_t e;
    e.at   = at;
    e.mask = mask;
    e.filt = filt;
    sb.push_back(e);
  endtask

  // Strobe monitor, sampling on the falling edge.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].at < cyc) begin
        check("sb_missed", 64'(cyc), 64'(sb[0].at));
        void'(sb.pop_front());
      end
      if (change_o != '0) begin
        if (sb.size() == 0) begin
          check("sb_unexpected", 64'(change_o), 64'(0));
        end else begin
          e = sb.pop_front();
          check("sb_cycle", 64'(cyc), 64'(e.at));
          check("sb_mask", 64'(change_o), 64'(e.mask));
          check("sb_filt", 64'(filtered_o), 64'(e.filt));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle pulse on the given lines (each line yields one glitch).
  task automatic pulse(input logic [N-1:0] lines);
    raw_i = lines;
    tick(1);
    raw_i = '0;
    tick(1);
  endtask

  int d;
  int rise;
  int fall;

  initial begin
    rst_n        = 1'b0;
    raw_i        = '0;
    freeze       = 1'b0;
    glitch_clear = 1'b0;
    tick(3);
    check("reset_filtered", 64'(filtered_o), 64'(0));
    check("reset_change", 64'(change_o), 64'(0));
    check("reset_glitch", 64'(glitch_count), 64'(0));
    rst_n = 1'b1;
    tick(3);

    // Clean rising edge on line 0.
    d = cyc;
    raw_i[0] = 1'b1;
    expect_event(d + SYNC + FILT, 4'b0001, 4'b0001);
    tick(SYNC + FILT - 1);
    check("clean_before", 64'(filtered_o[0]), 64'(0));
    tick(1);
    check("clean_after", 64'(filtered_o[0]), 64'(1));
    check("clean_strobe", 64'(change_o), 64'(4'b0001));
    tick(1);
    check("clean_strobe_end", 64'(change_o), 64'(0));
    check("clean_glitch", 64'(glitch_count), 64'(0));
    tick(10);
    d = cyc;
    raw_i[0] = 1'b0;
    expect_event(d + SYNC + FILT, 4'b0001, 4'b0000);
    tick(15);
    check("clean_sb_empty", 64'(sb.size()), 64'(0));

    // Three-cycle pulse on line 0: rejected as a glitch.
    raw_i[0] = 1'b1;
    tick(3);
    raw_i[0] = 1'b0;
    tick(8);
    check("glitch_filtered", 64'(filtered_o), 64'(0));
    check("glitch_count1", 64'(glitch_count), 64'(1));

    // 0->1->0 with the high phase lasting 5 cycles; the fall is hold-limited.
    d = cyc;
    raw_i[0] = 1'b1;
    rise = d + SYNC + FILT;
    fall = ((d + 5 + SYNC) > (rise + HOLD) ? (d + 5 + SYNC) : (rise + HOLD)) + FILT;
    expect_event(rise, 4'b0001, 4'b0001);
    expect_event(fall, 4'b0001, 4'b0000);
    tick(5);
    raw_i[0] = 1'b0;
    tick(15);
    check("retoggle_sb_empty", 64'(sb.size()), 64'(0));
    check("retoggle_filtered", 64'(filtered_o), 64'(0));

    // Simultaneous accepts on lines 1 and 3.
    d = cyc;
    raw_i = 4'b1010;
    expect_event(d + SYNC + FILT, 4'b1010, 4'b1010);
    tick(15);
    d = cyc;
    raw_i = 4'b0000;
    expect_event(d + SYNC + FILT, 4'b1010, 4'b0000);
    tick(15);
    check("multi_sb_empty", 64'(sb.size()), 64'(0));

    // All four lines glitch in the same cycle.
    glitch_clear = 1'b1;
    tick(1);
    glitch_clear = 1'b0;
    check("clear", 64'(glitch_count), 64'(0));
    raw_i = 4'b1111;
    tick(1);
    raw_i = 4'b0000;
    tick(2);
    check("quad_before", 64'(glitch_count), 64'(0));
    tick(1);
    check("quad_after", 64'(glitch_count), 64'(4));
    tick(5);

    // Saturation: bring the count to 16'hFFFC, then glitch four lines twice.
    glitch_clear = 1'b1;
    tick(1);
    glitch_clear = 1'b0;
    for (int p = 0; p < 16383; p++) pulse(4'b1111);
    tick(4);
    check("preload", 64'(glitch_count), 64'(16'hFFFC));
    pulse(4'b1111);
    tick(5);
    check("saturate", 64'(glitch_count), 64'(16'hFFFF));
    pulse(4'b1111);
    tick(5);
    check("saturate_hold", 64'(glitch_count), 64'(16'hFFFF));
    check("sat_filtered", 64'(filtered_o), 64'(0));

    // glitch_clear in the very cycle the glitches land.
    raw_i = 4'b1111;
    tick(1);
    raw_i = 4'b0000;
    tick(2);
    glitch_clear = 1'b1;
    tick(1);
    glitch_clear = 1'b0;
    check("clear_priority", 64'(glitch_count), 64'(0));
    tick(5);

    // Freeze while line 2 is qualifying with cnt = 2.
    raw_i[2] = 1'b1;
    tick(SYNC + 2);
    freeze = 1'b1;
    tick(1);
    check("freeze_track", 64'(filtered_o[2]), 64'(1));
    check("freeze_no_strobe", 64'(change_o), 64'(0));
    raw_i[2] = 1'b0;
    tick(SYNC);
    check("freeze_lag", 64'(filtered_o[2]), 64'(1));
    tick(1);
    check("freeze_follow", 64'(filtered_o[2]), 64'(0));
    raw_i[2] = 1'b1;
    tick(SYNC + 1);
    check("freeze_follow2", 64'(filtered_o[2]), 64'(1));
    freeze = 1'b0;
    tick(10);
    check("unfreeze_hold", 64'(filtered_o), 64'(4'b0100));
    check("unfreeze_glitch", 64'(glitch_count), 64'(0));
    d = cyc;
    raw_i[2] = 1'b0;
    expect_event(d + SYNC + FILT, 4'b0100, 4'b0000);
    tick(15);
    check("freeze_sb_empty", 64'(sb.size()), 64'(0));

    // Asynchronous reset while line 0 is holding.
    pulse(4'b0010);
    tick(5);
    check("pre_reset_glitch", 64'(glitch_count), 64'(1));
    d = cyc;
    raw_i[0] = 1'b1;
    expect_event(d + SYNC + FILT, 4'b0001, 4'b0001);
    tick(SYNC + FILT);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    raw_i = '0;
    #1;
    check("async_filtered", 64'(filtered_o), 64'(0));
    check("async_change", 64'(change_o), 64'(0));
    check("async_glitch", 64'(glitch_count), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(10);
    check("post_reset_filtered", 64'(filtered_o), 64'(0));
    d = cyc;
    raw_i[3] = 1'b1;
    expect_event(d + SYNC + FILT, 4'b1000, 4'b1000);
    tick(SYNC + FILT);
    check("post_reset_accept", 64'(filtered_o), 64'(4'b1000));
    tick(10);

    check("final_sb_empty", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
